// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder stimulus/checker: FSM states, LFSR
// polynomial, counter width and the expected-value pipeline entry.
package adder_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] LFSR_POLY = 32'hB4BC_D35C;
  localparam int          CNT_W     = 16;
  // Wide enough for the largest legal sum (32-bit operands plus carry).
  localparam int          MAX_SUM_W = 33;

  typedef struct packed {
    logic                 valid;
    logic [MAX_SUM_W-1:0] expected;
    logic [CNT_W-1:0]     index;
  } pipe_entry_t;

  // Right-shifting Galois step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/adder_chk_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed reload; a load that coincides with
// an advance yields the step after the seed, since the seed itself is issued.
module adder_chk_lfsr32
  import adder_chk_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n)       state <= SEED;
    else if (load)    state <= advance ? lfsr_next(SEED) : SEED;
    else if (advance) state <= lfsr_next(state);
  end

endmodule

// File: rtl/adder_stim_checker.sv
// Self-checking source/sink for a registered W-bit adder. Defining
// ADDER_CHK_STOP_ON_ERR_EN stops the run at the first mismatch and reports its index.
module adder_stim_checker
  import adder_chk_pkg::*;
#(
  parameter int          ADDER_WIDTH = 17,
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 1024,
  parameter logic [31:0] SEED_A      = 32'h1,
  parameter logic [31:0] SEED_B      = 32'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [ADDER_WIDTH-1:0] a,
  output logic [ADDER_WIDTH-1:0] b,
  input  logic [ADDER_WIDTH:0]   sum,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       fail_index
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t            state, state_next;
  logic              accept, issue, last_issue, mismatch, stop_hit;
  logic [CNT_W-1:0]  issue_cnt, issue_idx, stage_idx;
  logic              stage_valid;
  logic [31:0]       lfsr_a, lfsr_b, src_a, src_b;
  pipe_entry_t       pipe [LATENCY];
  pipe_entry_t       tail;
  logic              unused_bits;

  adder_chk_lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
    .clk(clk), .rst_n(rst_n), .load(accept), .advance(issue), .state(lfsr_a)
  );
  adder_chk_lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
    .clk(clk), .rst_n(rst_n), .load(accept), .advance(issue), .state(lfsr_b)
  );

  assign accept   = start && (state == IDLE || state == DONE);
  assign tail     = pipe[LATENCY-1];
  assign mismatch = tail.valid && (sum != tail.expected[ADDER_WIDTH:0]);

`ifdef ADDER_CHK_STOP_ON_ERR_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  // The start edge itself issues vector 0 straight from the seeds.
  assign issue      = accept || (state == RUN && !stop_hit);
  assign issue_idx  = accept ? '0 : issue_cnt;
  assign last_issue = issue && (issue_idx == LAST_IDX);
  assign src_a      = accept ? SEED_A : lfsr_a;
  assign src_b      = accept ? SEED_B : lfsr_b;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  assign unused_bits = &{1'b0, src_a, src_b, tail};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (accept) state_next = last_issue ? DRAIN : RUN;
      RUN: begin
        if (stop_hit)        state_next = DONE;
        else if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (stop_hit || (tail.valid && tail.index == LAST_IDX)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Expected sums are formed from the registered operands, so the pipeline is
  // LATENCY deep behind the operand register and lines up with sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a           <= '0;
      b           <= '0;
      issue_cnt   <= '0;
      stage_valid <= 1'b0;
      stage_idx   <= '0;
      err_count   <= '0;
      // NOTE: the pipeline is a handful of flops whose valid bits must not
      // survive reset, so it is reset as a whole rather than left as memory.
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      if (issue) begin
        a         <= src_a[ADDER_WIDTH-1:0];
        b         <= src_b[ADDER_WIDTH-1:0];
        issue_cnt <= issue_idx + CNT_W'(1);
      end
      stage_valid <= issue;
      stage_idx   <= issue_idx;

      if (stop_hit) begin
        for (int i = 0; i < LATENCY; i++) pipe[i].valid <= 1'b0;
      end else begin
        pipe[0] <= '{valid:    stage_valid,
                     expected: MAX_SUM_W'(a) + MAX_SUM_W'(b),
                     index:    stage_idx};
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end

      if (accept)                               err_count <= '0;
      else if (mismatch && err_count != '1)     err_count <= err_count + CNT_W'(1);
    end
  end

`ifdef ADDER_CHK_STOP_ON_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        fail_index <= '0;
    else if (accept)   fail_index <= '0;
    else if (stop_hit) fail_index <= tail.index;
  end
`else
  assign fail_index = '0;
`endif

endmodule
